// File: rtl/tia_object_position_counter.sv
// Position counter for TIA movable objects: wraps over a scanline, emits copy-start strobes
// and drives graphics scan position. Optional: TIA_OBJECT_POSITION_COUNTER_HMOVE_EN lets hm_en step it.
module tia_object_position_counter #(
    parameter int PERIOD = 160,
    parameter int CW     = 8,
    parameter int GW     = 8,
    parameter int CLOSE  = 16,
    parameter int MED    = 32,
    parameter int WIDE   = 64
) (
    input  logic                   clk,
    input  logic                   reset_bar,
    input  logic                   clk_en,
    input  logic                   resp,
    input  logic [2:0]             mode,
    input  logic                   hm_en,
    output logic [CW-1:0]          count,
    output logic                   start_bar,
    output logic                   pix_en,
    output logic [$clog2(GW)-1:0]  bit_idx,
    output logic [1:0]             copy_idx
);
    localparam int BW = $clog2(GW);

    typedef enum logic {IDLE, SCAN} state_t;

    // Handshake: none. ev_q is a one-cycle pulse that the scan FSM consumes
    // unconditionally on the following edge; there is no back-pressure.
    logic           adv;
    logic [CW-1:0]  count_step;
    logic           ev;
    logic [1:0]     ev_copy;
    logic [1:0]     scale_m1;
    logic           ev_q;
    logic [1:0]     ev_copy_q;
    logic [1:0]     ev_scl_q;

    state_t         state, state_d;
    logic [1:0]     sub, sub_d;
    logic [BW-1:0]  bit_d;
    logic [1:0]     copy_d;
    logic [1:0]     scl_q, scl_d;

`ifdef TIA_OBJECT_POSITION_COUNTER_HMOVE_EN
    assign adv = clk_en | hm_en;
`else
    logic unused_hm_en;
    assign unused_hm_en = hm_en;
    assign adv = clk_en;
`endif

    assign count_step = (count == CW'(PERIOD - 1)) ? '0 : count + CW'(1);

    // Starts are judged against the value count is about to take; a resp load never starts.
    always_comb begin
        ev      = 1'b0;
        ev_copy = 2'd0;
        if (adv && !resp) begin
            if (count == CW'(PERIOD - 1)) begin
                ev = 1'b1;
            end else begin
                case (mode)
                    3'd1: if (count_step == CW'(CLOSE)) begin ev = 1'b1; ev_copy = 2'd1; end
                    3'd2: if (count_step == CW'(MED))   begin ev = 1'b1; ev_copy = 2'd1; end
                    3'd3: begin
                        if (count_step == CW'(CLOSE))    begin ev = 1'b1; ev_copy = 2'd1; end
                        else if (count_step == CW'(MED)) begin ev = 1'b1; ev_copy = 2'd2; end
                    end
                    3'd4: if (count_step == CW'(WIDE))  begin ev = 1'b1; ev_copy = 2'd1; end
                    3'd6: begin
                        if (count_step == CW'(MED))       begin ev = 1'b1; ev_copy = 2'd1; end
                        else if (count_step == CW'(WIDE)) begin ev = 1'b1; ev_copy = 2'd2; end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        case (mode)
            3'd5:    scale_m1 = 2'd1;
            3'd7:    scale_m1 = 2'd3;
            default: scale_m1 = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            count     <= '0;
            ev_q      <= 1'b0;
            ev_copy_q <= 2'd0;
            ev_scl_q  <= 2'd0;
            start_bar <= 1'b1;
        end else begin
            if (resp)
                count <= '0;
            else if (adv)
                count <= count_step;
            ev_q      <= ev;
            ev_copy_q <= ev_copy;
            ev_scl_q  <= scale_m1;
            start_bar <= ~ev_q;
        end
    end

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            state    <= IDLE;
            sub      <= 2'd0;
            bit_idx  <= '0;
            copy_idx <= 2'd0;
            scl_q    <= 2'd0;
        end else begin
            state    <= state_d;
            sub      <= sub_d;
            bit_idx  <= bit_d;
            copy_idx <= copy_d;
            scl_q    <= scl_d;
        end
    end

    // A start always wins, so an overlapping copy truncates the one being scanned.
    always_comb begin
        state_d = state;
        sub_d   = sub;
        bit_d   = bit_idx;
        copy_d  = copy_idx;
        scl_d   = scl_q;
        if (ev_q) begin
            state_d = SCAN;
            sub_d   = 2'd0;
            bit_d   = '0;
            copy_d  = ev_copy_q;
            scl_d   = ev_scl_q;
        end else if (state == SCAN && adv) begin
            if (sub == scl_q) begin
                sub_d = 2'd0;
                if (bit_idx == BW'(GW - 1)) begin
                    state_d = IDLE;
                    bit_d   = '0;
                end else begin
                    bit_d = bit_idx + BW'(1);
                end
            end else begin
                sub_d = sub + 2'd1;
            end
        end
    end

    assign pix_en = (state == SCAN);

endmodule

// File: tb/tb_tia_object_position_counter.sv
// Bench for tia_object_position_counter: directed scenarios plus random stimulus, all
// checked every cycle against an elapsed-time model of counter and scan.
module tb_tia_object_position_counter;
    localparam int PERIOD = 160;
    localparam int GW     = 8;

    logic       clk = 1'b0;
    logic       reset_bar = 1'b0;
    logic       clk_en = 1'b0;
    logic       resp = 1'b0;
    logic [2:0] mode = 3'd0;
    logic       hm_en = 1'b0;
    logic [7:0] count;
    logic       start_bar;
    logic       pix_en;
    logic [2:0] bit_idx;
    logic [1:0] copy_idx;

    int total = 0;
    int bad = 0;
    bit sb_en = 1'b0;
    logic [1:0] exp_q[$];

    tia_object_position_counter dut (
        .clk(clk), .reset_bar(reset_bar), .clk_en(clk_en), .resp(resp), .mode(mode),
        .hm_en(hm_en), .count(count), .start_bar(start_bar), .pix_en(pix_en),
        .bit_idx(bit_idx), .copy_idx(copy_idx)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---- behavioural model: position plus elapsed advances since the last start ----
    int m_count, m_copy, m_el, m_scale;
    bit m_active, m_start;
    bit m_pend;
    int m_pend_copy, m_pend_scale;

    function automatic int copy_offset(input int md, input int slot);
        case (md)
            1: return (slot == 0) ? 16 : -1;
            2: return (slot == 0) ? 32 : -1;
            3: return (slot == 0) ? 16 : 32;
            4: return (slot == 0) ? 64 : -1;
            6: return (slot == 0) ? 32 : 64;
            default: return -1;
        endcase
    endfunction

    function automatic int scale_of(input int md);
        return (md == 5) ? 2 : (md == 7) ? 4 : 1;
    endfunction

    always @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            m_count = 0; m_copy = 0; m_el = 0; m_scale = 1;
            m_active = 0; m_start = 0; m_pend = 0; m_pend_copy = 0; m_pend_scale = 1;
        end else begin
            bit a;
            bit new_start;
            int ns_copy, ns_scale;
`ifdef TIA_OBJECT_POSITION_COUNTER_HMOVE_EN
            a = clk_en | hm_en;
`else
            a = clk_en;
`endif
            new_start = m_pend; ns_copy = m_pend_copy; ns_scale = m_pend_scale;
            m_pend = 0; m_pend_copy = 0; m_pend_scale = scale_of(int'(mode));
            if (a && !resp) begin
                if (m_count == PERIOD - 1) begin
                    m_pend = 1;
                end else begin
                    for (int i = 0; i < 2; i++)
                        if (!m_pend && copy_offset(int'(mode), i) == m_count + 1) begin
                            m_pend = 1; m_pend_copy = i + 1;
                        end
                end
            end
            if (resp) m_count = 0;
            else if (a) m_count = (m_count + 1) % PERIOD;
            m_start = new_start;
            if (new_start) begin
                m_active = 1; m_el = 0; m_copy = ns_copy; m_scale = ns_scale;
            end else if (m_active && a) begin
                m_el++;
                if (m_el == GW * m_scale) m_active = 0;
            end
        end
    end

    // ---- compare process + start scoreboard ----
    always @(negedge clk) begin
        if (reset_bar) begin
            check("count", int'(count), m_count);
            check("start_bar", int'(start_bar), m_start ? 0 : 1);
            check("pix_en", int'(pix_en), int'(m_active));
            check("bit_idx", int'(bit_idx), m_active ? m_el / m_scale : 0);
            check("copy_idx", int'(copy_idx), m_copy);
            if (sb_en && !start_bar) begin
                if (exp_q.size() == 0) check("unexpected_start", 1, 0);
                else check("start_copy", int'(copy_idx), int'(exp_q.pop_front()));
            end
        end
    end

    // ---- driver tasks ----
    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_count(input int val, input string name);
        int n = 0;
        while (int'(count) != val && n < 400) begin run(1); n++; end
        if (n >= 400) check({name, "_timeout"}, 1, 0);
    endtask

    task automatic wait_start(input string name);
        int n = 0;
        while (start_bar && n < 400) begin run(1); n++; end
        if (n >= 400) check({name, "_timeout"}, 1, 0);
    endtask

    task automatic measure_scan(input string name, input int exp_len);
        int n = 0;
        wait_start(name);
        while (pix_en && n < 100) begin run(1); n++; end
        check(name, n, exp_len);
    endtask

    initial begin
        int saved, n;
        clk_en = 1'b1; mode = 3'd0;
        #12;
        // reset values, asynchronous, before any clock edge
        check("rst_count", int'(count), 0);
        check("rst_start_bar", int'(start_bar), 1);
        check("rst_pix_en", int'(pix_en), 0);
        check("rst_bit_idx", int'(bit_idx), 0);
        check("rst_copy_idx", int'(copy_idx), 0);
        @(negedge clk); reset_bar = 1'b1;

        // mode 0: run one full line, then the primary start after the wrap
        run(159);
        check("line_count_159", int'(count), 159);
        run(1);
        check("wrap_count", int'(count), 0);
        check("wrap_no_strobe_yet", int'(start_bar), 1);
        run(1);
        check("primary_strobe", int'(start_bar), 0);
        check("primary_pix", int'(pix_en), 1);
        run(7);
        check("primary_last_bit", int'(bit_idx), 7);
        run(1);
        check("primary_end", int'(pix_en), 0);

        // mode 3: copies at 16 and 32, then primary after wrap
        mode = 3'd3; sb_en = 1'b1;
        exp_q.push_back(2'd1); exp_q.push_back(2'd2); exp_q.push_back(2'd0);
        run(160);
        check("mode3_starts_seen", exp_q.size(), 0);
        sb_en = 1'b0; exp_q.delete();

        // scaled widths
        mode = 3'd7; run(2);
        measure_scan("mode7_len", 32);
        mode = 3'd5; run(2);
        measure_scan("mode5_len", 16);

        // resp at 100 in mode 1: no primary, copy 1 at 16, primary after 160 advances
        mode = 3'd1;
        wait_count(100, "resp_wait");
        resp = 1'b1; run(1); resp = 1'b0;
        check("resp_count", int'(count), 0);
        sb_en = 1'b1;
        exp_q.push_back(2'd1); exp_q.push_back(2'd0);
        run(165);
        check("resp_starts_seen", exp_q.size(), 0);
        sb_en = 1'b0; exp_q.delete();

        // freeze mid-scan at bit 3
        mode = 3'd0;
        n = 0;
        while (!(pix_en && bit_idx == 3'd3) && n < 400) begin run(1); n++; end
        if (n >= 400) check("hold_timeout", 1, 0);
        saved = int'(count);
        clk_en = 1'b0; run(10);
        check("hold_bit", int'(bit_idx), 3);
        check("hold_count", int'(count), saved);
        check("hold_pix", int'(pix_en), 1);
        clk_en = 1'b1; run(5);
        check("resume_count", int'(count), saved + 5);
        check("resume_end", int'(pix_en), 0);

        // HMOVE pulses with motion clock off
        wait_count(20, "hm_wait");
        clk_en = 1'b0; hm_en = 1'b1; run(8);
`ifdef TIA_OBJECT_POSITION_COUNTER_HMOVE_EN
        check("hmove_count", int'(count), 28);
`else
        check("hmove_count", int'(count), 20);
`endif
        hm_en = 1'b0; clk_en = 1'b1;

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            clk_en = ($urandom_range(0, 9) != 0);
            hm_en  = ($urandom_range(0, 15) == 0);
            resp   = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 99) == 0) mode = 3'($urandom_range(0, 7));
            run(1);
        end
        resp = 1'b0; hm_en = 1'b0; clk_en = 1'b1; mode = 3'd0;

        // reset in the middle of a scan
        n = 0;
        while (!pix_en && n < 400) begin run(1); n++; end
        if (n >= 400) check("midrst_timeout", 1, 0);
        reset_bar = 1'b0; #1;
        check("midrst_pix", int'(pix_en), 0);
        check("midrst_count", int'(count), 0);
        check("midrst_bit", int'(bit_idx), 0);
        run(2);
        reset_bar = 1'b1;
        run(20);
        check("after_rst_count", int'(count), 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tia_object_position_counter.md
# tia_object_position_counter

Parametrised position counter for TIA movable objects (players, missiles, ball). It generalises the fixed player counter to configurable line period, copy spacing and graphics width, with NUSIZ-style copy and width modes. The block runs on a single pixel clock with enables in place of the two-phase clock, and sits between the object register file and the object graphics shifter. It emits copy-start strobes plus scan position (`copy_idx`, `bit_idx`) so the shifter needs no counting logic of its own.

## Interface
- `PERIOD`, 160: positions per scanline; count wraps `PERIOD-1` -> 0.
- `CW`, 8: counter width; 2^CW >= PERIOD.
- `GW`, 8: graphics bits per copy; power of two, >= 2.
- `CLOSE`, 16: close copy offset.
- `MED`, 32: medium copy offset.
- `WIDE`, 64: wide copy offset. All offsets < PERIOD.

Ports:
- `clk` in 1: pixel clock; all state changes on rising edge.
- `reset_bar` in 1: reset, asynchronous, active-low.
- `clk_en` in 1: motion clock enable; high on visible pixel clocks.
- `resp` in 1: position reset strobe.
- `mode` in 3: copy/size mode, NUSIZ encoding.
- `hm_en` in 1: extra HMOVE motion pulse (see Configuration).
- `count` out CW: current position.
- `start_bar` out 1: active-low copy-start strobe, one clk wide.
- `pix_en` out 1: graphics scan active.
- `bit_idx` out clog2(GW): graphics bit being scanned, 0 = first.
- `copy_idx` out 2: copy being scanned (0 primary, 1, 2).

## Operation
- `adv` = `clk_en` (| `hm_en` when the macro is compiled in). There is at most one step per clk.
- Counter:
  - On `adv`: `count` <= (`count`==PERIOD-1) ? 0 : `count`+1.
  - `resp` loads 0 and overrides `adv`.
- Start events are evaluated on an `adv` cycle, against the value `count` takes after that cycle:
  - Primary (copy 0) at 0, but only when reached by wrap.
  - Copies per `mode`:
    - 0: none.
    - 1: CLOSE.
    - 2: MED.
    - 3: CLOSE, MED.
    - 4: WIDE.
    - 5: none, scale 2.
    - 6: MED, WIDE.
    - 7: none, scale 4.
  - Scale is 1 for modes other than 5 and 7.
- A load of 0 via `resp` generates no primary start. Copy starts at later offsets on the same line still fire.
- Scan FSM, states IDLE and SCAN, with sub-pixel counter `sub` (0..scale-1):
  - Start event: go to SCAN, `bit_idx`=0, `sub`=0, `copy_idx`=copy number. Scale is latched from `mode`.
  - In SCAN on `adv`:
    - If `sub`==scale-1: `sub`=0, and `bit_idx`++.
    - If `bit_idx` is already GW-1 at that point, return to IDLE.
    - Otherwise `sub`++.
  - `pix_en` = (state==SCAN).
- A start event during SCAN restarts the scan (`bit_idx`=0, new `copy_idx`). Overlapping copies truncate the earlier one.
- `resp` does not affect an in-progress scan.
- `mode` changes mid-scan: offsets are used live; scale changes only at the next start.
- `clk_en`=0 and no `hm_en`: counter, `sub` and `bit_idx` are all frozen.

## Timing
- Reset values: `count`=0, `start_bar`=1, `pix_en`=0, `bit_idx`=0, `copy_idx`=0, FSM IDLE, `sub`=0.
- Reset mid-scan aborts immediately and asynchronously.
- All outputs are registered; no combinational input-to-output paths.
- Event on edge N: at edge N+1, `start_bar`=0 for one clk, `pix_en`=1, `bit_idx`=0.
- A scan lasts GW*scale `adv` cycles after the start edge.
- `resp` at edge N: `count`=0 after edge N. If a start for offset 0 coincides, it is suppressed.

## Configuration
- `TIA_OBJECT_POSITION_COUNTER_HMOVE_EN`:
  - Defined: `hm_en` ORs into `adv`. HMOVE pulses step the counter and scan, and can trigger starts.
  - Undefined: `hm_en` is ignored (the port remains) and `adv` = `clk_en`.

## Test plan
- Reset, `mode`=0, `clk_en`=1: `count` runs 0..159 and wraps. Edge after wrap: `start_bar` low 1 clk, `copy_idx`=0, `pix_en` high 8 clks, `bit_idx` 0..7.
- `mode`=3 over one line: starts at `count` 0, 16, 32 with `copy_idx` 0, 1, 2; each scan 8 clks.
- `mode`=7: `pix_en` high 32 clks, `bit_idx` steps every 4 clks; no copies. `mode`=5: 16 clks, steps every 2.
- `mode`=1, `resp` at `count`=100: `count`=0 next edge with no start. `copy_idx`=1 start after reaching 16. Primary start after the next wrap, 160 advances later.
- Scan at `bit_idx`=3, `clk_en` low 10 clks: `count`, `bit_idx` and `pix_en` are held, then resume.
- `clk_en`=0, `hm_en`=1 for 8 clks from `count`=20: with macro `count`=28; without macro `count`=20.
